// File: rtl/instruction_fetch.sv
// Instruction fetch unit: IDLE/FETCH/ISSUE sequencer with Branch/Jump PC redirect.
// Define INSTRUCTION_FETCH_DELAY_SLOT_EN for MIPS branch-delay-slot behaviour.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] pc_out_r;
    logic        imem_req_r;
    logic        instr_valid_r;
    logic        fetch_done_s;
    logic        issue_done_s;
    logic [31:0] seq_pc_s;
    logic [31:0] jump_tgt_s;
    logic [31:0] branch_tgt_s;
    logic [31:0] redirect_tgt_s;
    logic [31:0] next_pc_s;
    logic        redirect_s;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // Next-state decode and handshake strobes.
    always_comb begin
        next_state_s = state_r;
        fetch_done_s = 1'b0;
        issue_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                next_state_s = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    next_state_s = ISSUE;
                    fetch_done_s = 1'b1;
                end else begin
                    next_state_s = FETCH;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    next_state_s = FETCH;
                    issue_done_s = 1'b1;
                end else begin
                    next_state_s = ISSUE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Redirect target; Jump wins over a taken Branch.
    always_comb begin
        seq_pc_s     = pc_out_r + 32'd4;
        jump_tgt_s   = {seq_pc_s[31:28], instr_r[25:0], 2'b00};
        branch_tgt_s = seq_pc_s + branch_offset(instr_r[15:0]);
        redirect_s   = Jump | (Branch & Zero);
        if (Jump) begin
            redirect_tgt_s = jump_tgt_s;
        end else if (Branch && Zero) begin
            redirect_tgt_s = branch_tgt_s;
        end else begin
            redirect_tgt_s = seq_pc_s;
        end
    end

`ifdef INSTRUCTION_FETCH_DELAY_SLOT_EN
    logic        ds_pending_r;
    logic [31:0] ds_target_r;

    // Next PC: the slot instruction follows sequentially, then the latched target.
    always_comb begin
        if (ds_pending_r) begin
            next_pc_s = ds_target_r;
        end else begin
            next_pc_s = seq_pc_s;
        end
    end

    // Pending redirect; Branch/Jump of the slot instruction itself are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ds_pending_r <= 1'b0;
            ds_target_r  <= 32'h00000000;
        end else if (issue_done_s) begin
            if (ds_pending_r) begin
                ds_pending_r <= 1'b0;
            end else if (redirect_s) begin
                ds_pending_r <= 1'b1;
                ds_target_r  <= redirect_tgt_s;
            end
        end
    end
`else
    // Next PC: redirect applies to the very next fetch.
    always_comb begin
        if (redirect_s) begin
            next_pc_s = redirect_tgt_s;
        end else begin
            next_pc_s = seq_pc_s;
        end
    end
`endif

    // State, registered strobes, held instruction and PC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= IDLE;
            pc_r          <= RESET_PC;
            instr_r       <= 32'h00000000;
            pc_out_r      <= 32'h00000000;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            imem_req_r    <= (next_state_s == FETCH);
            instr_valid_r <= (next_state_s == ISSUE);
            if (fetch_done_s) begin
                instr_r  <= imem_rdata;
                pc_out_r <= pc_r;
            end
            if (issue_done_s) begin
                pc_r <= next_pc_s;
            end
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr_out   = instr_r;
    assign pc_out      = pc_out_r;
    assign instr_valid = instr_valid_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the PC sequence.
`timescale 1ns/1ps
module tb_instruction_fetch;
    localparam logic [31:0] RST_PC = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        Branch = 1'b0;
    logic        Jump = 1'b0;
    logic        Zero = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .Branch(Branch), .Jump(Jump), .Zero(Zero)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] ovr[logic [31:0]];
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_target = 32'h0;
    bit          m_slot = 1'b0;
    int          cyc = 0;
    int          issues = 0;
    int          last_hs = 0;
    int          idle_cnt = 0;
    bit          hs_prev = 1'b0;
    bit          full_speed = 1'b0;
    bit          rst_seen = 1'b0;
    int          mem_mode = 0;

    // Instruction memory contents: overrides for directed cases, else a hash of the address.
    function automatic logic [31:0] memw(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (a * 32'h9E3779B1) ^ 32'h3C6EF372 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor / scoreboard: observe at negedge, predict what the next posedge does.
    always @(negedge clk) begin
        logic [31:0] seq;
        logic [31:0] tgt;
        bit          taken;
        cyc++;
        if (rst_seen) begin
            check("rst_imem_req", {31'd0, imem_req}, 32'd0);
            check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
            check("rst_instr_out", instr_out, 32'd0);
            check("rst_pc_out", pc_out, 32'd0);
            check("rst_imem_addr", imem_addr, RST_PC);
        end
        rst_seen = 1'b0;
        if (instr_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: instr_valid=1 pc_out=%h with no fetched instruction", pc_out);
            end else begin
                check("instr_out", instr_out, exp_q[0].instr);
                check("pc_out", pc_out, exp_q[0].pc);
                check("issue_req_low", {31'd0, imem_req}, 32'd0);
            end
        end
        if (imem_req) check("imem_addr", imem_addr, m_pc);

        if (!rst) begin
            exp_q.delete();
            m_pc     = RST_PC;
            m_slot   = 1'b0;
            hs_prev  = 1'b0;
            idle_cnt = 0;
            rst_seen = 1'b1;
        end else begin
            if (imem_req && imem_ready) exp_q.push_back({m_pc, memw(m_pc)});
            if (instr_valid && instr_ready && exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                seq   = e.pc + 32'd4;
                taken = 1'b1;
                if (Jump) tgt = (seq & 32'hF000_0000) | ((e.instr & 32'h03FF_FFFF) << 2);
                else if (Branch && Zero) tgt = seq + 32'(int'(shortint'(e.instr[15:0])) * 4);
                else begin
                    tgt   = seq;
                    taken = 1'b0;
                end
`ifdef INSTRUCTION_FETCH_DELAY_SLOT_EN
                if (m_slot) begin
                    m_pc   = m_target;
                    m_slot = 1'b0;
                end else if (taken) begin
                    m_target = tgt;
                    m_slot   = 1'b1;
                    m_pc     = seq;
                end else begin
                    m_pc = seq;
                end
`else
                m_pc = taken ? tgt : seq;
`endif
                if (full_speed && hs_prev) check("issue_gap", 32'(cyc - last_hs), 32'd2);
                last_hs  = cyc;
                hs_prev  = full_speed;
                issues++;
                idle_cnt = 0;
            end else begin
                idle_cnt++;
                if (idle_cnt > 64) begin
                    total++;
                    bad++;
                    $display("FAIL watchdog: no issue for %0d cycles, required at most 64", idle_cnt);
                    idle_cnt = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (mem_mode)
            0: imem_ready = imem_req;
            1: imem_ready = ($urandom_range(0, 3) != 0);
            default: ;
        endcase
        imem_rdata = imem_req ? memw(imem_addr) : $urandom();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        instr_ready = 1'b0;
        Branch = 1'b0;
        Jump = 1'b0;
        Zero = 1'b0;
        repeat (3) step();
        rst = 1'b1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 50) begin
            step();
            n++;
        end
        if (!instr_valid) begin
            total++;
            bad++;
            $display("FAIL wait_valid: instr_valid stayed 0 for 50 cycles, required 1");
        end
    endtask

    task automatic issue_one(input logic b, input logic j, input logic z);
        wait_valid();
        instr_ready = 1'b1;
        Branch = b;
        Jump = j;
        Zero = z;
        step();
        instr_ready = 1'b0;
        Branch = 1'b0;
        Jump = 1'b0;
        Zero = 1'b0;
    endtask

    task automatic expect_fetch(input string name, input logic [31:0] addr);
        int n = 0;
        while (!imem_req && n < 50) begin
            step();
            n++;
        end
        check({name, "_req"}, {31'd0, imem_req}, 32'd1);
        check(name, imem_addr, addr);
    endtask

    initial begin
        // Sequential fetch at full speed.
        do_reset();
        mem_mode = 0;
        full_speed = 1'b1;
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_fetch("seq_addr", 32'(k * 4));
            step();
        end
        instr_ready = 1'b0;
        full_speed = 1'b0;

        // Jump from 0x0 to 0x40.
        ovr[32'h0] = 32'h08000010;
        do_reset();
        issue_one(1'b0, 1'b1, 1'b0);
`ifdef INSTRUCTION_FETCH_DELAY_SLOT_EN
        expect_fetch("jump_delay_slot", 32'h4);
        issue_one(1'b0, 1'b0, 1'b0);
`endif
        expect_fetch("jump_target", 32'h40);

        // Branch at 0x100: taken, not taken, Jump priority.
        ovr[32'h0]   = 32'h08000040;
        ovr[32'h100] = 32'h1000FFFF;
        ovr[32'h104] = 32'h1000FFFF;
        do_reset();
`ifdef INSTRUCTION_FETCH_DELAY_SLOT_EN
        issue_one(1'b0, 1'b1, 1'b0);
        expect_fetch("ds_after_jump", 32'h4);
        issue_one(1'b0, 1'b0, 1'b0);
        expect_fetch("jump_0x100", 32'h100);
        issue_one(1'b1, 1'b0, 1'b1);
        expect_fetch("ds_after_branch", 32'h104);
        issue_one(1'b1, 1'b1, 1'b1);
        expect_fetch("branch_target_slot_ignored", 32'h100);
`else
        issue_one(1'b0, 1'b1, 1'b0);
        expect_fetch("jump_0x100", 32'h100);
        issue_one(1'b1, 1'b0, 1'b1);
        expect_fetch("branch_taken", 32'h100);
        issue_one(1'b1, 1'b0, 1'b0);
        expect_fetch("branch_not_taken", 32'h104);
        issue_one(1'b1, 1'b1, 1'b1);
        expect_fetch("jump_priority", 32'h0003FFFC);
`endif

        // Decode stall: outputs held, no request.
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_req_low", {31'd0, imem_req}, 32'd0);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        issue_one(1'b0, 1'b0, 1'b0);

        // Reset during a stalled fetch; late imem_ready must be discarded.
        do_reset();
        issue_one(1'b0, 1'b1, 1'b0);
        mem_mode = 2;
        imem_ready = 1'b0;
        for (int n = 0; n < 50 && !imem_req; n++) step();
        step();
        rst = 1'b0;
        step();
        imem_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        mem_mode = 0;
        expect_fetch("refetch_reset_pc", RST_PC);
        wait_valid();
        check("refetch_instr", instr_out, memw(RST_PC));

        // Branch back from 0x0 to 0xFFFFFFFC, then wrap to 0x0.
        ovr[32'h0] = 32'h1000FFFE;
        do_reset();
        issue_one(1'b1, 1'b0, 1'b1);
`ifdef INSTRUCTION_FETCH_DELAY_SLOT_EN
        expect_fetch("wrap_delay_slot", 32'h4);
        issue_one(1'b0, 1'b0, 1'b0);
`endif
        expect_fetch("wrap_top", 32'hFFFFFFFC);
        issue_one(1'b0, 1'b0, 1'b0);
        expect_fetch("wrap_zero", 32'h0);

        // Randomized traffic with occasional resets.
        ovr.delete();
        do_reset();
        mem_mode = 1;
        issues = 0;
        for (int k = 0; k < 4000; k++) begin
            instr_ready = 1'($urandom_range(0, 1));
            Jump   = ($urandom_range(0, 7) == 0);
            Branch = ($urandom_range(0, 3) == 0);
            Zero   = 1'($urandom_range(0, 1));
            rst    = ($urandom_range(0, 299) != 0);
            step();
        end
        rst = 1'b1;
        check("random_issue_count_min", {31'd0, (issues >= 300)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL set the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 imem_req  output  1  SHALL request an instruction-memory read at imem_addr.
REQ-005 imem_addr  output  32  SHALL carry the word-aligned fetch address.
REQ-006 imem_ready  input  1  SHALL mark imem_rdata valid for the outstanding request.
REQ-007 imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-008 instr_out  output  32  SHALL carry the held instruction, driven to the control unit's Opcode input.
REQ-009 pc_out  output  32  SHALL carry the address of instr_out.
REQ-010 instr_valid  output  1  SHALL mark instr_out as issuable.
REQ-011 instr_ready  input  1  SHALL indicate decode accepts instr_out this cycle.
REQ-012 Branch, Jump  input  1 each  SHALL be the control unit's decode of instr_out.
REQ-013 Zero  input  1  SHALL be the ALU zero flag for the instruction on instr_out.

Function
REQ-014 FSM SHALL have states IDLE, FETCH, ISSUE; IDLE->FETCH unconditionally one cycle after reset release.
REQ-015 In FETCH: imem_req=1, imem_addr=pc; on imem_ready: instr_reg<=imem_rdata, pc_out<=pc, go ISSUE in the next cycle; otherwise hold FETCH with stable imem_addr.
REQ-016 In ISSUE: instr_valid=1, imem_req=0; imem_ready SHALL be ignored.
REQ-017 Issue handshake SHALL occur on a cycle with instr_valid & instr_ready; Branch, Jump and Zero SHALL be sampled only in that cycle; FSM then returns to FETCH.
REQ-018 Next PC at handshake: Jump -> {pc_out+4[31:28], instr[25:0], 2'b00}; else Branch & Zero -> pc_out+4 + (sign_extend(instr[15:0]) << 2); else pc_out+4.
REQ-019 Jump SHALL take priority over Branch when both are high; Branch with Zero=0 SHALL yield pc_out+4.
REQ-020 PC arithmetic SHALL be 32-bit modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
REQ-021 instr_out and pc_out SHALL remain stable while instr_valid=1 and instr_ready=0.
REQ-022 Throughput SHALL be at most one instruction per two cycles (FETCH, ISSUE), plus imem wait cycles.

Reset
REQ-023 While rst=0 at a clock edge: state<=IDLE, pc<=RESET_PC, instr_reg<=0, pc_out<=0; outputs imem_req=0, instr_valid=0.
REQ-024 Reset asserted mid-FETCH SHALL abandon the request; an imem_ready arriving in or after that cycle SHALL be discarded.
REQ-025 Reset asserted mid-ISSUE SHALL drop the held instruction with no PC update.

Configuration
REQ-026 Macro INSTRUCTION_FETCH_DELAY_SLOT_EN SHALL select MIPS branch-delay-slot behaviour.
REQ-027 Defined: a taken redirect SHALL be latched as pending target; next fetch SHALL be pc_out+4 (delay slot), the fetch after SHALL be the target; Branch/Jump of the delay-slot instruction SHALL be ignored.
REQ-028 Undefined: redirect SHALL apply to the immediately following fetch; no delay slot exists.

Verification
REQ-029 Reset then imem_ready=1 each FETCH, instr_ready=1, no Branch/Jump -> imem_addr sequence 0x0, 0x4, 0x8, one issue every 2 cycles.
REQ-030 Issue 0x08000010 at pc 0x0 with Jump=1 -> next imem_addr 0x00000040 (macro undefined) / 0x4 then 0x40 (macro defined).
REQ-031 Issue 0x1000FFFF at pc 0x100 with Branch=1, Zero=1 -> next imem_addr 0x100 (undefined); with Zero=0 -> 0x104.
REQ-032 instr_ready=0 for 5 cycles in ISSUE -> instr_out, pc_out stable, imem_req=0, no PC change.
REQ-033 imem_ready delayed 3 cycles; rst=0 on the 2nd -> IDLE, late imem_ready ignored, refetch from RESET_PC.
REQ-034 RESET_PC=32'hFFFFFFFC, sequential issue -> next imem_addr 0x00000000.
